datapath: RTL and testbench

Execution datapath for the simple 16-bit RISC processor. It contains:

- an 8×16 register file with a write-back selector;
- A/B operand registers;
- a barrel shifter on the B path and operand muxes;
- a 4-function ALU, the C result register and a 3-bit status register.

The controller FSM drives all load, select and opcode inputs each cycle.

---
 rtl/datapath_if.sv | 35 +++
 rtl/datapath.sv | 152 +++++++++++++++
 tb/tb_datapath.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// Controller-to-datapath bundle: control, select and data inputs plus the C and status outputs.
interface datapath_if;
   logic [15:0] sximm8;
   logic [15:0] sximm5;
   logic [7:0]  PC;
   logic [15:0] mdata;
   logic [3:0]  vsel;
   logic        write;
   logic [2:0]  writenum;
   logic [2:0]  readnum;
   logic        loada;
   logic        loadb;
   logic        asel;
   logic        bsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic        loadc;
   logic        loads;
   logic [15:0] datapath_out;
   logic [2:0]  Z_out;

   // Controller side
   modport master (
      output sximm8, sximm5, PC, mdata, vsel, write, writenum, readnum,
             loada, loadb, asel, bsel, shift, ALUop, loadc, loads,
      input  datapath_out, Z_out
   );

   // Datapath side
   modport slave (
      input  sximm8, sximm5, PC, mdata, vsel, write, writenum, readnum,
             loada, loadb, asel, bsel, shift, ALUop, loadc, loads,
      output datapath_out, Z_out
   );
endinterface

// File: rtl/datapath.sv
// Execution datapath: 8x16 register file, A/B operand registers, B-path shifter,
// 4-function ALU, C result register and status register.
// Optional feature macro: DATAPATH_NV_FLAGS_EN (adds N and V flags; otherwise only Z).
module datapath (
   input  logic       clk,
   input  logic       rst_n,
   datapath_if.slave  bus
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NREGS  = 8;

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_c;

   logic [DATA_W-1:0] w_data_in;
   logic [DATA_W-1:0] w_data_out;
   logic [DATA_W-1:0] w_sout;
   logic [DATA_W-1:0] w_ain;
   logic [DATA_W-1:0] w_bin;
   logic [DATA_W-1:0] w_alu;
   logic              w_z;

   // Write-back source select; unrecognised codes write zero
   always_comb begin
      w_data_in = '0;
      case (bus.vsel)
         4'b0001: w_data_in = r_c;
         4'b0010: w_data_in = bus.sximm8;
         4'b0100: w_data_in = {8'b0, bus.PC};
         4'b1000: w_data_in = bus.mdata;
         default: w_data_in = '0;
      endcase
   end

   // Register file storage; reads are combinational so A/B see pre-edge contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            r_regs[i] <= '0;
         end
      end else if (bus.write) begin
         r_regs[bus.writenum] <= w_data_in;
      end
   end

   assign w_data_out = r_regs[bus.readnum];

   // Operand registers A and B
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         if (bus.loada) r_a <= w_data_out;
         if (bus.loadb) r_b <= w_data_out;
      end
   end

   // Shifter on the B path
   always_comb begin
      w_sout = r_b;
      case (bus.shift)
         2'b00: w_sout = r_b;
         2'b01: w_sout = {r_b[DATA_W-2:0], 1'b0};
         2'b10: w_sout = {1'b0, r_b[DATA_W-1:1]};
         2'b11: w_sout = {r_b[DATA_W-1], r_b[DATA_W-1:1]};
         default: w_sout = r_b;
      endcase
   end

   assign w_ain = bus.asel ? '0 : r_a;
   assign w_bin = bus.bsel ? bus.sximm5 : w_sout;

   // ALU: add, subtract, bitwise AND, invert B
   always_comb begin
      w_alu = '0;
      case (bus.ALUop)
         2'b00: w_alu = w_ain + w_bin;
         2'b01: w_alu = w_ain - w_bin;
         2'b10: w_alu = w_ain & w_bin;
         2'b11: w_alu = ~w_bin;
         default: w_alu = '0;
      endcase
   end

   assign w_z = (w_alu == '0);

   // Result register C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c <= '0;
      end else if (bus.loadc) begin
         r_c <= w_alu;
      end
   end

   assign bus.datapath_out = r_c;

`ifdef DATAPATH_NV_FLAGS_EN
   logic       w_n;
   logic       w_v;
   logic       w_bsign;
   logic [2:0] r_status;

   // Signed overflow: effective operand signs agree but the result sign differs
   always_comb begin
      w_bsign = w_bin[DATA_W-1];
      w_v     = 1'b0;
      case (bus.ALUop)
         2'b00: begin
            w_bsign = w_bin[DATA_W-1];
            w_v     = (w_ain[DATA_W-1] == w_bsign) && (w_alu[DATA_W-1] != w_ain[DATA_W-1]);
         end
         2'b01: begin
            w_bsign = ~w_bin[DATA_W-1];
            w_v     = (w_ain[DATA_W-1] == w_bsign) && (w_alu[DATA_W-1] != w_ain[DATA_W-1]);
         end
         default: w_v = 1'b0;
      endcase
   end

   assign w_n = w_alu[DATA_W-1];

   // Status register {Z, N, V}
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_status <= '0;
      end else if (bus.loads) begin
         r_status <= {w_z, w_n, w_v};
      end
   end

   assign bus.Z_out = r_status;
`else
   logic r_z;

   // Status register, zero flag only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z <= 1'b0;
      end else if (bus.loads) begin
         r_z <= w_z;
      end
   end

   assign bus.Z_out = {r_z, 2'b00};
`endif

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios followed by random control
// sequences, all compared against a behavioural model of the register-level machine.
module tb_datapath;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   datapath_if bus ();

   datapath u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [15:0] m_r [8];
   logic [15:0] m_a;
   logic [15:0] m_b;
   logic [15:0] m_c;
   logic [2:0]  m_f;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Flags visible on Z_out for the current build
   function automatic logic [2:0] vis_flags(input logic [2:0] f);
`ifdef DATAPATH_NV_FLAGS_EN
      return f;
`else
      return {f[2], 2'b00};
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      m_a = '0;
      m_b = '0;
      m_c = '0;
      m_f = '0;
   endtask

   task automatic idle();
      bus.sximm8 = '0; bus.sximm5 = '0; bus.PC = '0; bus.mdata = '0;
      bus.vsel = 4'b0000; bus.write = 1'b0; bus.writenum = '0; bus.readnum = '0;
      bus.loada = 1'b0; bus.loadb = 1'b0; bus.asel = 1'b0; bus.bsel = 1'b0;
      bus.shift = 2'b00; bus.ALUop = 2'b00; bus.loadc = 1'b0; bus.loads = 1'b0;
   endtask

   // One clock edge: evaluate the model from pre-edge state, then compare outputs
   task automatic tick(input string tag);
      logic [15:0] din, rd, sout, ain, bin, res;
      int          sa, sb, s;
      logic        v;
      case (bus.vsel)
         4'b0001: din = m_c;
         4'b0010: din = bus.sximm8;
         4'b0100: din = 16'(int'(bus.PC));
         4'b1000: din = bus.mdata;
         default: din = 16'h0000;
      endcase
      rd = m_r[bus.readnum];
      case (bus.shift)
         2'd0: sout = m_b;
         2'd1: sout = 16'(int'(m_b) * 2);
         2'd2: sout = 16'(int'(m_b) / 2);
         default: sout = 16'($signed(m_b) >>> 1);
      endcase
      ain = bus.asel ? 16'h0000 : m_a;
      bin = bus.bsel ? bus.sximm5 : sout;
      sa  = int'($signed(ain));
      sb  = int'($signed(bin));
      v   = 1'b0;
      case (bus.ALUop)
         2'd0: begin s = sa + sb; res = 16'(s); v = (s > 32767) || (s < -32768); end
         2'd1: begin s = sa - sb; res = 16'(s); v = (s > 32767) || (s < -32768); end
         2'd2: res = ain & bin;
         default: res = ~bin;
      endcase
      @(posedge clk);
      if (bus.write) m_r[bus.writenum] = din;
      if (bus.loada) m_a = rd;
      if (bus.loadb) m_b = rd;
      if (bus.loadc) m_c = res;
      if (bus.loads) m_f = {res == 16'h0000, res[15], v};
      #1;
      check({tag, "_c"}, bus.datapath_out, m_c);
      check({tag, "_flags"}, 16'(bus.Z_out), 16'(vis_flags(m_f)));
   endtask

   // Write an immediate into a register, then load it into A and/or B
   task automatic load_reg(input logic [2:0] rn, input logic [15:0] val, input logic la, input logic lb);
      idle();
      bus.vsel = 4'b0010; bus.sximm8 = val; bus.write = 1'b1; bus.writenum = rn;
      tick("wr");
      idle();
      bus.readnum = rn; bus.loada = la; bus.loadb = lb;
      tick("ld");
   endtask

   initial begin
      clk      = 1'b0;
      n_checks = 0;
      n_errors = 0;
      model_reset();
      idle();

      // Reset with busy inputs: outputs cleared immediately and held through edges
      rst_n = 1'b0;
      bus.vsel = 4'b0010; bus.sximm8 = 16'h1234; bus.write = 1'b1; bus.loada = 1'b1;
      bus.loadb = 1'b1; bus.loadc = 1'b1; bus.loads = 1'b1; bus.sximm5 = 16'h0055; bus.bsel = 1'b1;
      #1;
      check("rst_c", bus.datapath_out, 16'h0000);
      check("rst_flags", 16'(bus.Z_out), 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_c", bus.datapath_out, 16'h0000);
      check("rst_hold_flags", 16'(bus.Z_out), 16'h0000);
      idle();
      #2 rst_n = 1'b1;

      // All registers read zero after reset: sum every R via A and B
      for (int i = 0; i < 8; i++) begin
         idle();
         bus.readnum = 3'(i); bus.loada = 1'b1; bus.loadb = 1'b1;
         tick("rdz");
         idle();
         bus.ALUop = 2'b00; bus.loadc = 1'b1; bus.loads = 1'b1;
         tick("rdz_alu");
         check("rst_reg_zero", bus.datapath_out, 16'h0000);
      end

      // R0=7 into B, R1=2 into A, then A + (B<<1) = 16
      load_reg(3'd0, 16'd7, 1'b0, 1'b1);
      load_reg(3'd1, 16'd2, 1'b1, 1'b0);
      idle();
      bus.shift = 2'b01; bus.ALUop = 2'b00; bus.loadc = 1'b1; bus.loads = 1'b1;
      tick("plan_add");
      check("plan_add_val", bus.datapath_out, 16'd16);
      check("plan_add_z", 16'(bus.Z_out), 16'h0000);

      // 5 - 5 = 0 sets Z
      load_reg(3'd2, 16'd5, 1'b1, 1'b1);
      idle();
      bus.ALUop = 2'b01; bus.loadc = 1'b1; bus.loads = 1'b1;
      tick("plan_sub");
      check("plan_sub_val", bus.datapath_out, 16'h0000);
      check("plan_sub_z", 16'(bus.Z_out), 16'(vis_flags(3'b100)));

      // 7FFF + 1 overflows
      load_reg(3'd3, 16'h7FFF, 1'b1, 1'b0);
      load_reg(3'd4, 16'h0001, 1'b0, 1'b1);
      idle();
      bus.ALUop = 2'b00; bus.loadc = 1'b1; bus.loads = 1'b1;
      tick("plan_ovf");
      check("plan_ovf_val", bus.datapath_out, 16'h8000);
      check("plan_ovf_nv", 16'(bus.Z_out), 16'(vis_flags(3'b011)));

      // Write C back into R6, then pass it through A
      idle();
      bus.vsel = 4'b0001; bus.write = 1'b1; bus.writenum = 3'd6;
      tick("wb");
      idle();
      bus.readnum = 3'd6; bus.loada = 1'b1;
      tick("wb_ld");
      idle();
      bus.bsel = 1'b1; bus.sximm5 = 16'h0000; bus.ALUop = 2'b00; bus.loadc = 1'b1;
      tick("wb_pass");
      check("wb_val", bus.datapath_out, 16'h8000);
      check("flags_held", 16'(bus.Z_out), 16'(vis_flags(3'b011)));

      // ~FFFF with Ain forced to zero
      idle();
      bus.asel = 1'b1; bus.bsel = 1'b1; bus.sximm5 = 16'hFFFF; bus.ALUop = 2'b11;
      bus.loadc = 1'b1; bus.loads = 1'b1;
      tick("plan_not");
      check("plan_not_val", bus.datapath_out, 16'h0000);
      check("plan_not_z", 16'(bus.Z_out), 16'(vis_flags(3'b100)));

      // Same-cycle write and read of one register: load sees the old value
      idle();
      bus.vsel = 4'b0100; bus.PC = 8'hA5; bus.write = 1'b1; bus.writenum = 3'd7;
      bus.readnum = 3'd7; bus.loadb = 1'b1;
      tick("raw");
      idle();
      bus.asel = 1'b1; bus.ALUop = 2'b00; bus.loadc = 1'b1;
      tick("raw_old");
      check("raw_old_val", bus.datapath_out, 16'h0000);

      // Random control sequences with occasional mid-cycle reset
      for (int n = 0; n < 600; n++) begin
         logic [3:0] vs;
         case ($urandom_range(0, 4))
            0: vs = 4'b0001;
            1: vs = 4'b0010;
            2: vs = 4'b0100;
            3: vs = 4'b1000;
            default: vs = 4'($urandom);
         endcase
         bus.vsel     = vs;
         bus.sximm8   = 16'($urandom);
         bus.sximm5   = 16'($urandom);
         bus.PC       = 8'($urandom);
         bus.mdata    = 16'($urandom);
         bus.write    = 1'($urandom);
         bus.writenum = 3'($urandom);
         bus.readnum  = 3'($urandom);
         bus.loada    = 1'($urandom);
         bus.loadb    = 1'($urandom);
         bus.asel     = ($urandom_range(0, 5) == 0);
         bus.bsel     = ($urandom_range(0, 3) == 0);
         bus.shift    = 2'($urandom);
         bus.ALUop    = 2'($urandom);
         bus.loadc    = 1'($urandom);
         bus.loads    = 1'($urandom);
         if ($urandom_range(0, 59) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check("mid_rst_c", bus.datapath_out, 16'h0000);
            check("mid_rst_flags", 16'(bus.Z_out), 16'h0000);
            #1 rst_n = 1'b1;
         end
         tick("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
